// File: rtl/mux2to1_day2a_if.sv
// Bundle for mux2to1_day2a data, select, valid and registered outputs.
// Optional par_q signal exists only when MUX2TO1_PARITY_EN is defined.
interface mux2to1_day2a_if #(
  parameter int WIDTH     = 4,
  parameter int SEL_CNT_W = 8
);
  logic [WIDTH-1:0]     d0;
  logic [WIDTH-1:0]     d1;
  logic                 s;
  logic                 in_valid;
  logic [WIDTH-1:0]     y;
  logic [WIDTH-1:0]     y_q;
  logic                 out_valid;
  logic [SEL_CNT_W-1:0] sel_cnt;
`ifdef MUX2TO1_PARITY_EN
  logic                 par_q;
`endif

  modport master (
    output d0,
    output d1,
    output s,
    output in_valid,
    input  y,
    input  y_q,
    input  out_valid,
`ifdef MUX2TO1_PARITY_EN
    input  par_q,
`endif
    input  sel_cnt
  );

  modport slave (
    input  d0,
    input  d1,
    input  s,
    input  in_valid,
    output y,
    output y_q,
    output out_valid,
`ifdef MUX2TO1_PARITY_EN
    output par_q,
`endif
    output sel_cnt
  );
endinterface

// File: rtl/mux2to1_day2a.sv
// 2:1 mux with registered copy, valid, select-switch counter.
// Define MUX2TO1_PARITY_EN to add the registered parity output par_q.
module mux2to1_day2a #(
  parameter int WIDTH     = 4,
  parameter int SEL_CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  mux2to1_day2a_if.slave   bus
);

  logic [WIDTH-1:0]     y_c;
  logic [WIDTH-1:0]     y_q_r;
  logic                 vld_r;
  logic [SEL_CNT_W-1:0] cnt_r;
  logic                 last_s;
  logic                 seen;
  logic                 bump;

  // Unknown select propagates as X in simulation.
  always_comb begin
    y_c = 'x;
    unique case (bus.s)
      1'b0:    y_c = bus.d0;
      1'b1:    y_c = bus.d1;
      default: y_c = 'x;
    endcase
  end

  assign bump = bus.in_valid && seen &&
                (bus.s != last_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q_r  <= '0;
      vld_r  <= 1'b0;
      cnt_r  <= '0;
      last_s <= 1'b0;
      seen   <= 1'b0;
    end else begin
      vld_r <= bus.in_valid;
      if (bus.in_valid) begin
        y_q_r  <= y_c;
        last_s <= bus.s;
        seen   <= 1'b1;
      end
      if (bump)
        cnt_r <= cnt_r + 1'b1;
    end
  end

`ifdef MUX2TO1_PARITY_EN
  logic par_r;

  always_ff @(posedge clk) begin
    if (rst)
      par_r <= 1'b0;
    else if (bus.in_valid)
      par_r <= ^y_c;
  end

  assign bus.par_q = par_r;
`endif

  assign bus.y         = y_c;
  assign bus.y_q       = y_q_r;
  assign bus.out_valid = vld_r;
  assign bus.sel_cnt   = cnt_r;

endmodule

// File: tb/tb_mux2to1_day2a.sv
// Directed self-checking bench for mux2to1_day2a.
// Parity checks run when MUX2TO1_PARITY_EN is defined.
module tb_mux2to1_day2a;

  localparam int W  = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mux2to1_day2a_if #(
    .WIDTH(W),
    .SEL_CNT_W(CW)
  ) bus ();

  mux2to1_day2a #(
    .WIDTH(W),
    .SEL_CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(
    input string       tag,
    input logic [3:0]  eyq,
    input logic        evld,
    input logic [7:0]  ecnt
  );
    check({tag, ".y_q"}, 32'(bus.y_q), 32'(eyq));
    check({tag, ".vld"}, 32'(bus.out_valid),
          32'(evld));
    check({tag, ".cnt"}, 32'(bus.sel_cnt),
          32'(ecnt));
  endtask

  logic [3:0] ys [4];
  logic       ss [4];
  logic [7:0] cs [4];

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.d0       = 4'b0001;
    bus.d1       = 4'b1111;
    bus.s        = 1'b0;
    #1;
    check("comb_s0", 32'(bus.y), 32'h1);
    bus.s = 1'b1;
    #1;
    check("comb_s1", 32'(bus.y), 32'hf);
    bus.d0 = 4'b1010;
    bus.d1 = 4'b0101;
    bus.s  = 1'b0;
    #1;
    check("comb_a", 32'(bus.y), 32'ha);
    bus.s = 1'b1;
    #1;
    check("comb_b", 32'(bus.y), 32'h5);

    cyc();
    cyc();
    chk_reg("rst", 4'h0, 1'b0, 8'd0);
`ifdef MUX2TO1_PARITY_EN
    check("rst.par", 32'(bus.par_q), 32'h0);
`endif

    rst = 1'b0;
    ss = '{1'b0, 1'b1, 1'b1, 1'b0};
    ys = '{4'ha, 4'h5, 4'h5, 4'ha};
    cs = '{8'd0, 8'd1, 8'd1, 8'd2};
    for (int i = 0; i < 4; i++) begin
      bus.s        = ss[i];
      bus.in_valid = 1'b1;
      cyc();
      chk_reg($sformatf("str%0d", i),
              ys[i], 1'b1, cs[i]);
    end

    bus.in_valid = 1'b0;
    bus.d0       = 4'h3;
    bus.s        = 1'b1;
    cyc();
    chk_reg("hold", 4'ha, 1'b0, 8'd2);

    bus.in_valid = 1'b1;
    for (int i = 1; i <= 253; i++) begin
      bus.s = i[0];
      cyc();
    end
    check("cnt_max", 32'(bus.sel_cnt), 32'd255);
    bus.s = 1'b0;
    cyc();
    check("cnt_wrap", 32'(bus.sel_cnt), 32'd0);

    rst   = 1'b1;
    bus.s = 1'b1;
    bus.d1 = 4'h6;
    #1;
    check("rst_comb", 32'(bus.y), 32'h6);
    cyc();
    chk_reg("rst_iv", 4'h0, 1'b0, 8'd0);

    rst   = 1'b0;
    bus.s = 1'b1;
    cyc();
    chk_reg("first", 4'h6, 1'b1, 8'd0);
    cyc();
    check("same_s", 32'(bus.sel_cnt), 32'd0);
    bus.s = 1'b0;
    cyc();
    chk_reg("sw", 4'h3, 1'b1, 8'd1);

`ifdef MUX2TO1_PARITY_EN
    bus.s  = 1'b0;
    bus.d0 = 4'b0111;
    cyc();
    check("par1", 32'(bus.par_q), 32'h1);
    bus.d0 = 4'b0101;
    cyc();
    check("par0", 32'(bus.par_q), 32'h0);
    bus.in_valid = 1'b0;
    bus.d0       = 4'b0111;
    cyc();
    check("par_hold", 32'(bus.par_q), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
